// File: rtl/sdm_decimator.sv
`default_nettype none
// ============================================================================
//  Module      : sdm_decimator
//  Description : Third-order CIC decimator (differential delay 1) that turns
//                a 1-bit sigma-delta stream into 16-bit signed PCM words.
//                Three wrapping integrators run at the din_en rate. Every
//                DECIM samples the last integrator feeds three combs. The comb
//                result is scaled to 17 bits and then reduced to 16 bits.
//  Ports       : clk        - single clock for all state
//                rst_n      - asynchronous active-low reset
//                din_en     - sample strobe; din is used only when high
//                din        - bitstream bit (1 = +1, 0 = -1)
//                clr        - synchronous restart of filter and warm-up
//                dout       - signed PCM word, held between valid pulses
//                dout_valid - one-cycle pulse qualifying dout
//  Parameter   : DECIM      - decimation ratio, power of two in 32..256
//  Option      : SDM_DEC_SAT_EN - when defined, clamp the 17-bit scaled value
//                to the 16-bit range. When undefined, keep its low 16 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdm_decimator #(
    parameter int DECIM = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din_en,
    input  logic        din,
    input  logic        clr,
    output logic [15:0] dout,
    output logic        dout_valid
);

    localparam int L     = $clog2(DECIM);
    localparam int W     = 3 * L + 2;
    localparam int SHIFT = 3 * L - 15;

    // Reject any ratio that is not a power of two within 32..256.
    generate
        if ((DECIM < 32) || (DECIM > 256) || ((DECIM & (DECIM - 1)) != 0)) begin : g_bad_decim
            $error("sdm_decimator: DECIM must be a power of two in 32..256");
        end
    endgenerate

    // Filter state.
    logic signed [W-1:0] r_int1, r_int2, r_int3;
    logic signed [W-1:0] r_dly1, r_dly2, r_dly3;
    logic [L-1:0]        r_cnt;
    logic [1:0]          r_warm;

    // Combinational datapath.
    logic signed [W-1:0] w_x;
    logic signed [W-1:0] w_int3_next;
    logic signed [W-1:0] w_comb1, w_comb2, w_comb3;
    logic                w_wrap;
    logic [15:0]         w_dout_next;

    assign w_x         = din ? W'(1) : {W{1'b1}};
    // The captured frame value includes the current sample's update.
    assign w_int3_next = r_int3 + r_int2;
    // DECIM is a power of two, so an all-ones count marks the frame end.
    assign w_wrap      = din_en & (&r_cnt);

    // The combs only need to produce a result on the wrap cycle. They run
    // combinationally from the new int3 value, so the result lands in dout
    // on the same clock edge that closes the frame.
    assign w_comb1 = w_int3_next - r_dly1;
    assign w_comb2 = w_comb1 - r_dly2;
    assign w_comb3 = w_comb2 - r_dly3;

`ifdef SDM_DEC_SAT_EN
    logic signed [16:0] w_scaled;

    assign w_scaled = 17'(w_comb3 >>> SHIFT);

    // The 17-bit value lies in -2^15..+2^15. It overflows 16 bits only when
    // bits 16 and 15 differ, and then the sign bit selects the clamp.
    always_comb begin
        w_dout_next = w_scaled[15:0];
        if (w_scaled[16] != w_scaled[15]) begin
            w_dout_next = w_scaled[16] ? 16'h8000 : 16'h7FFF;
        end
    end
`else
    // Keeping the low 16 bits lets +2^15 wrap to -32768.
    assign w_dout_next = 16'(w_comb3 >>> SHIFT);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int1     <= '0;
            r_int2     <= '0;
            r_int3     <= '0;
            r_dly1     <= '0;
            r_dly2     <= '0;
            r_dly3     <= '0;
            r_cnt      <= '0;
            r_warm     <= 2'd0;
            dout       <= 16'h0000;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (clr) begin
                // clr wins over din_en. dout keeps its last word.
                r_int1 <= '0;
                r_int2 <= '0;
                r_int3 <= '0;
                r_dly1 <= '0;
                r_dly2 <= '0;
                r_dly3 <= '0;
                r_cnt  <= '0;
                r_warm <= 2'd0;
            end else if (din_en) begin
                // Cascaded registers: each stage adds the previous value of
                // the stage before it.
                r_int1 <= r_int1 + w_x;
                r_int2 <= r_int2 + r_int1;
                r_int3 <= w_int3_next;
                r_cnt  <= r_cnt + L'(1);
                if (w_wrap) begin
                    r_dly1 <= w_int3_next;
                    r_dly2 <= w_comb1;
                    r_dly3 <= w_comb2;
                    dout   <= w_dout_next;
                    // The comb delays start at zero. The first two words are
                    // therefore incomplete and are not flagged.
                    if (r_warm == 2'd2) begin
                        dout_valid <= 1'b1;
                    end else begin
                        r_warm <= r_warm + 2'd1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdm_decimator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdm_decimator
//  Description : Self-checking bench for sdm_decimator with DECIM = 64.
//                The reference model works with exact integers. The third
//                integrator has the closed form
//                int3(n) = sum_k x_k * C(n-1-k, 2).
//                Each decimated word is the third finite difference of the
//                frame captures. Its result is scaled, then saturated or
//                truncated, to match the active configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdm_decimator;

    localparam int R  = 64;
    localparam int L  = 6;
    localparam int SH = 3 * L - 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din_en = 1'b0;
    logic        din = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;

    always #5 clk = ~clk;

    sdm_decimator #(.DECIM(R)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_en     (din_en),
        .din        (din),
        .clr        (clr),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    // Reference model state.
    longint             xs[$];
    longint             fr[$];
    logic signed [15:0] exp_dout  = 16'sh0000;
    logic               exp_valid = 1'b0;

`ifdef SDM_DEC_SAT_EN
    localparam int FULL_POS = 32767;
`else
    localparam int FULL_POS = -32768;
`endif

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic longint int3_at(input int n);
        longint s = 0;
        for (int k = 0; k < n; k++) begin
            longint i = longint'(n - 1 - k);
            s += xs[k] * ((i * (i - 1)) / 2);
        end
        return s;
    endfunction

    function automatic longint getf(input int j);
        return (j <= 0) ? 64'sd0 : fr[j-1];
    endfunction

    task automatic model_sample(input logic d);
        int     m;
        longint y, sc;
        xs.push_back(d ? 64'sd1 : -64'sd1);
        if ((xs.size() % R) == 0) begin
            m = xs.size() / R;
            fr.push_back(int3_at(xs.size()));
            y  = getf(m) - 3 * getf(m - 1) + 3 * getf(m - 2) - getf(m - 3);
            sc = y >>> SH;
`ifdef SDM_DEC_SAT_EN
            if (sc > 32767) sc = 32767;
            if (sc < -32768) sc = -32768;
`endif
            exp_dout  = sc[15:0];
            exp_valid = (m >= 3);
        end
    endtask

    // Apply one clock of inputs, advance the model, then check both outputs.
    task automatic step(input logic c, input logic e, input logic d);
        clr = c; din_en = e; din = d;
        exp_valid = 1'b0;
        if (c) begin
            xs.delete();
            fr.delete();
        end else if (e) begin
            model_sample(d);
        end
        @(posedge clk); #1;
        cyc++;
        check("dout_valid", longint'(dout_valid), longint'(exp_valid));
        check("dout", longint'($signed(dout)), longint'(exp_dout));
    endtask

    // One input sample followed by 'gap' idle cycles with a changing din.
    task automatic send(input logic d, input int gap);
        step(1'b0, 1'b1, d);
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    // Pulse reset asynchronously between clock edges. Check the reset
    // values, then release reset.
    task automatic pulse_reset();
        rst_n = 1'b0; din_en = 1'b0; clr = 1'b0;
        #2;
        check("reset_dout", longint'($signed(dout)), 0);
        check("reset_valid", longint'(dout_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        xs.delete();
        fr.delete();
        exp_dout  = 16'sh0000;
        exp_valid = 1'b0;
    endtask

    // pattern: 0 = all ones, 1 = all zeros, 2 = alternating 1,0, 3 = random
    typedef struct {
        int pattern;
        int gap;
        int nsamp;
        int exp_const;
        bit has_const;
    } vec_t;

    function automatic logic pat_bit(input int pattern, input int s, input int pct);
        case (pattern)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return ((s % 2) == 0);
            default: return ($urandom_range(0, 99) < pct);
        endcase
    endfunction

    initial begin
        vec_t vecs[4];
        int   first, nvalid, last_cyc, pct, first_clr, first_rst;
        logic signed [15:0] held;

        vecs[0] = '{pattern: 0, gap: 0, nsamp: 5 * R, exp_const: FULL_POS, has_const: 1'b1};
        vecs[1] = '{pattern: 1, gap: 0, nsamp: 5 * R, exp_const: -32768,   has_const: 1'b1};
        vecs[2] = '{pattern: 2, gap: 0, nsamp: 5 * R, exp_const: 0,        has_const: 1'b1};
        vecs[3] = '{pattern: 0, gap: 2, nsamp: 5 * R, exp_const: FULL_POS, has_const: 1'b1};

        #2;
        check("por_dout", longint'($signed(dout)), 0);
        check("por_valid", longint'(dout_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table-driven checks on fixed patterns.
        foreach (vecs[v]) begin
            step(1'b1, 1'b0, 1'b0);
            first = -1; nvalid = 0; last_cyc = 0;
            for (int s = 0; s < vecs[v].nsamp; s++) begin
                step(1'b0, 1'b1, pat_bit(vecs[v].pattern, s, 50));
                if (dout_valid) begin
                    if (first < 0) begin
                        first = s + 1;
                        check("first_valid_sample", first, 3 * R);
                    end else begin
                        check("valid_spacing", cyc - last_cyc, (vecs[v].gap + 1) * R);
                    end
                    if (vecs[v].has_const)
                        check("pattern_dout", longint'($signed(dout)), vecs[v].exp_const);
                    last_cyc = cyc;
                    nvalid++;
                end
                for (int g = 0; g < vecs[v].gap; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            end
            check("valid_count", nvalid, vecs[v].nsamp / R - 2);
        end

        // Randomized density and gaps, checked against the model.
        for (int t = 0; t < 6; t++) begin
            step(1'b1, 1'b0, 1'b0);
            pct = $urandom_range(0, 100);
            for (int s = 0; s < 5 * R + $urandom_range(0, R); s++)
                send(pat_bit(3, s, pct), $urandom_range(0, 3));
        end

        // clr arrives together with din_en at sample 100. A reset follows
        // mid-frame at sample 300.
        step(1'b1, 1'b0, 1'b0);
        for (int s = 1; s < 100; s++) send(1'($urandom_range(0, 1)), 0);
        held = exp_dout;
        step(1'b1, 1'b1, 1'b1);
        check("dout_held_clr", longint'($signed(dout)), longint'(held));
        first_clr = -1;
        for (int s = 1; s <= 200; s++) begin
            send(1'($urandom_range(0, 1)), 0);
            if (dout_valid && first_clr < 0) first_clr = s;
        end
        check("first_valid_after_clr", first_clr, 3 * R);
        pulse_reset();
        first_rst = -1;
        for (int s = 1; s <= 4 * R; s++) begin
            send(1'($urandom_range(0, 1)), 0);
            if (dout_valid && first_rst < 0) first_rst = s;
        end
        check("first_valid_after_reset", first_rst, 3 * R);

        // Reset in the middle of the warm-up of a constant-ones stream.
        for (int s = 0; s < 40; s++) send(1'b1, 1);
        pulse_reset();
        for (int s = 0; s < 4 * R; s++) send(1'b1, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
